// File: rtl/i2c_req_arbiter.sv
// Two-requester round-robin arbiter that owns the I2C master command port.
// It sequences Start/Ready and reports Error or a timeout back to the winner.
module i2c_req_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Req0,
    input  logic       Req1,
    input  logic [6:0] Adr0,
    input  logic [6:0] Adr1,
    input  logic [7:0] Pointer0,
    input  logic [7:0] Pointer1,
    input  logic       Set_pointer0,
    input  logic       Set_pointer1,
    input  logic [7:0] Data_in0,
    input  logic [7:0] Data_in0b,
    input  logic [7:0] Data_in1,
    input  logic [7:0] Data_in1b,
    input  logic       R_W0,
    input  logic       R_W1,
    output logic       Ack0,
    output logic       Ack1,
    output logic       Err,
    output logic       Tout,
    output logic       Gnt,
    output logic       Busy,
    output logic [6:0] Adr,
    output logic [7:0] Pointer,
    output logic       Set_pointer,
    output logic [7:0] Data_in,
    output logic [7:0] Data_in2,
    output logic       R_W,
    output logic       Start,
    input  logic       Error,
    input  logic       Ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    state_t      state, state_nx;
    logic        last, last_nx;
    logic        gnt_nx, start_nx, ack0_nx, ack1_nx, err_nx, tout_nx;
    logic [15:0] cnt, cnt_nx;
    logic [6:0]  adr_nx;
    logic [7:0]  pointer_nx, data_in_nx, data_in2_nx;
    logic        set_pointer_nx, r_w_nx;
    logic        win, timed_out;

    // Under contention the side that was not served last wins.
    assign win       = Req1 & ~(Req0 & last);
    assign timed_out = (cnt == TIMEOUT - 16'd1);
    assign Busy      = (state != IDLE);

    always_comb begin
        state_nx       = state;
        last_nx        = last;
        gnt_nx         = Gnt;
        start_nx       = Start;
        ack0_nx        = Ack0;
        ack1_nx        = Ack1;
        err_nx         = Err;
        tout_nx        = Tout;
        cnt_nx         = cnt;
        adr_nx         = Adr;
        pointer_nx     = Pointer;
        set_pointer_nx = Set_pointer;
        data_in_nx     = Data_in;
        data_in2_nx    = Data_in2;
        r_w_nx         = R_W;
        unique case (state)
            IDLE: begin
                if (Ready && (Req0 || Req1)) begin
                    adr_nx         = win ? Adr1 : Adr0;
                    pointer_nx     = win ? Pointer1 : Pointer0;
                    set_pointer_nx = win ? Set_pointer1 : Set_pointer0;
                    data_in_nx     = win ? Data_in1 : Data_in0;
                    data_in2_nx    = win ? Data_in1b : Data_in0b;
                    r_w_nx         = win ? R_W1 : R_W0;
                    gnt_nx         = win;
                    last_nx        = win;
                    start_nx       = 1'b1;
                    cnt_nx         = '0;
                    state_nx       = ISSUE;
                end
            end
            ISSUE: begin
                if (!Ready) begin
                    start_nx = 1'b0;
                    cnt_nx   = '0;
                    state_nx = BUSY;
                end else if (timed_out) begin
                    start_nx = 1'b0;
                    err_nx   = 1'b0;
                    tout_nx  = 1'b1;
                    ack0_nx  = ~Gnt;
                    ack1_nx  = Gnt;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            BUSY: begin
                if (Ready) begin
                    err_nx   = Error;
                    tout_nx  = 1'b0;
                    ack0_nx  = ~Gnt;
                    ack1_nx  = Gnt;
                    state_nx = DONE;
                end else if (timed_out) begin
                    err_nx   = 1'b0;
                    tout_nx  = 1'b1;
                    ack0_nx  = ~Gnt;
                    ack1_nx  = Gnt;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            DONE: begin
                ack0_nx  = 1'b0;
                ack1_nx  = 1'b0;
                err_nx   = 1'b0;
                tout_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            Gnt         <= 1'b0;
            Start       <= 1'b0;
            Ack0        <= 1'b0;
            Ack1        <= 1'b0;
            Err         <= 1'b0;
            Tout        <= 1'b0;
            cnt         <= '0;
            Adr         <= '0;
            Pointer     <= '0;
            Set_pointer <= 1'b0;
            Data_in     <= '0;
            Data_in2    <= '0;
            R_W         <= 1'b0;
        end else begin
            state       <= state_nx;
            last        <= last_nx;
            Gnt         <= gnt_nx;
            Start       <= start_nx;
            Ack0        <= ack0_nx;
            Ack1        <= ack1_nx;
            Err         <= err_nx;
            Tout        <= tout_nx;
            cnt         <= cnt_nx;
            Adr         <= adr_nx;
            Pointer     <= pointer_nx;
            Set_pointer <= set_pointer_nx;
            Data_in     <= data_in_nx;
            Data_in2    <= data_in2_nx;
            R_W         <= r_w_nx;
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: requester and master behaviour models drive a main
// instance; a second instance with a short TIMEOUT exercises the abort paths.
module tb_i2c_req_arbiter;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Rst = 1'b1, Rst_t = 1'b1;
    logic       Req0 = 1'b0, Req1 = 1'b0, Req0_t = 1'b0, Req1_t = 1'b0;
    logic [6:0] Adr0 = '0, Adr1 = '0;
    logic [7:0] Pointer0 = '0, Pointer1 = '0;
    logic       Set_pointer0 = 1'b0, Set_pointer1 = 1'b0;
    logic [7:0] Data_in0 = '0, Data_in0b = '0, Data_in1 = '0, Data_in1b = '0;
    logic       R_W0 = 1'b0, R_W1 = 1'b0;
    logic       Error = 1'b0, Ready = 1'b1, Error_t = 1'b0, Ready_t = 1'b1;

    logic       Ack0, Ack1, Err, Tout, Gnt, Busy, Set_pointer, R_W, Start;
    logic [6:0] Adr;
    logic [7:0] Pointer, Data_in, Data_in2;
    logic       Ack0_t, Ack1_t, Err_t, Tout_t, Gnt_t, Busy_t, Set_pointer_t, R_W_t, Start_t;
    logic [6:0] Adr_t;
    logic [7:0] Pointer_t, Data_in_t, Data_in2_t;

    i2c_req_arbiter #(.TIMEOUT(16'd200)) dut (
        .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1), .Adr0(Adr0), .Adr1(Adr1),
        .Pointer0(Pointer0), .Pointer1(Pointer1), .Set_pointer0(Set_pointer0),
        .Set_pointer1(Set_pointer1), .Data_in0(Data_in0), .Data_in0b(Data_in0b),
        .Data_in1(Data_in1), .Data_in1b(Data_in1b), .R_W0(R_W0), .R_W1(R_W1),
        .Ack0(Ack0), .Ack1(Ack1), .Err(Err), .Tout(Tout), .Gnt(Gnt), .Busy(Busy),
        .Adr(Adr), .Pointer(Pointer), .Set_pointer(Set_pointer), .Data_in(Data_in),
        .Data_in2(Data_in2), .R_W(R_W), .Start(Start), .Error(Error), .Ready(Ready));

    i2c_req_arbiter #(.TIMEOUT(16'd16)) dut_t (
        .Clk(Clk), .Rst(Rst_t), .Req0(Req0_t), .Req1(Req1_t), .Adr0(Adr0), .Adr1(Adr1),
        .Pointer0(Pointer0), .Pointer1(Pointer1), .Set_pointer0(Set_pointer0),
        .Set_pointer1(Set_pointer1), .Data_in0(Data_in0), .Data_in0b(Data_in0b),
        .Data_in1(Data_in1), .Data_in1b(Data_in1b), .R_W0(R_W0), .R_W1(R_W1),
        .Ack0(Ack0_t), .Ack1(Ack1_t), .Err(Err_t), .Tout(Tout_t), .Gnt(Gnt_t), .Busy(Busy_t),
        .Adr(Adr_t), .Pointer(Pointer_t), .Set_pointer(Set_pointer_t), .Data_in(Data_in_t),
        .Data_in2(Data_in2_t), .R_W(R_W_t), .Start(Start_t), .Error(Error_t), .Ready(Ready_t));

    logic [32:0] cmd_now, cmd_t, snap_f0, snap_f1;
    assign cmd_now = {Adr, Pointer, Set_pointer, Data_in, Data_in2, R_W};
    assign cmd_t   = {Adr_t, Pointer_t, Set_pointer_t, Data_in_t, Data_in2_t, R_W_t};

    int total = 0, bad = 0;

    // ---------------- requester model ----------------
    int rem[2] = '{0, 0};
    int gap[2] = '{0, 0};
    int gap_max = 0;
    bit fld_rand = 1'b0;

    task automatic rand_fields(input int id);
        if (id == 0) begin
            Adr0 = 7'($urandom); Pointer0 = 8'($urandom); Set_pointer0 = 1'($urandom);
            Data_in0 = 8'($urandom); Data_in0b = 8'($urandom); R_W0 = 1'($urandom);
        end else begin
            Adr1 = 7'($urandom); Pointer1 = 8'($urandom); Set_pointer1 = 1'($urandom);
            Data_in1 = 8'($urandom); Data_in1b = 8'($urandom); R_W1 = 1'($urandom);
        end
    endtask

    task automatic requester(input int id);
        logic req, ack, mine;
        forever begin
            @(posedge Clk); #1;
            req  = (id == 0) ? Req0 : Req1;
            ack  = (id == 0) ? Ack0 : Ack1;
            mine = (id == 0) ? !Gnt : Gnt;
            if (req) begin
                if (ack) begin
                    if (id == 0) Req0 = 1'b0; else Req1 = 1'b0;
                    rem[id]--;
                    gap[id] = int'($urandom_range(gap_max, 0));
                end else if (fld_rand && Busy && mine) begin
                    rand_fields(id);
                end
            end else if (rem[id] > 0) begin
                if (gap[id] > 0) gap[id]--;
                else begin
                    if (fld_rand) rand_fields(id);
                    if (id == 0) Req0 = 1'b1; else Req1 = 1'b1;
                end
            end
        end
    endtask

    initial requester(0);
    initial requester(1);

    // ---------------- master model ----------------
    int m_drop = 1, m_busy = 2, mph = 0, msc = 0, mbc = 0;
    bit m_err = 1'b0, m_rand = 1'b0;
    bit err_q[$];

    initial forever begin
        @(posedge Clk); #2;
        if (Rst) begin
            Ready = 1'b1; Error = 1'b0; mph = 0; msc = 0;
        end else begin
            case (mph)
                0: if (Start) begin
                    if (msc == 0) begin
                        if (m_rand) begin
                            m_drop = int'($urandom_range(3, 0));
                            m_busy = int'($urandom_range(6, 1));
                            m_err  = 1'($urandom);
                        end
                        err_q.push_back(m_err);
                    end
                    msc++;
                    if (msc == m_drop + 1) begin Ready = 1'b0; mph = 1; mbc = 0; end
                end
                1: begin
                    mbc++;
                    if (mbc >= m_busy) begin Ready = 1'b1; Error = m_err; mph = 2; end
                end
                default: if (Ack0 || Ack1) begin Error = 1'b0; mph = 0; msc = 0; end
            endcase
        end
    end

    // ---------------- monitor and arbitration reference ----------------
    typedef struct {
        int who, exp_who, gnt, c_start, c_ack, start_len;
        bit err, tout, ready_ok;
        logic [32:0] cmd, cmd_ack, exp_cmd;
    } obs_t;
    obs_t obs_q[$];
    obs_t cur;
    int cyc = 0, ack_long = 0;
    bit st_prev = 1'b0, ack_prev = 1'b0, mdl_last = 1'b1;
    bit snap_req0, snap_req1, snap_ready, snap_rst;

    always @(posedge Clk) begin
        snap_rst = Rst; snap_req0 = Req0; snap_req1 = Req1; snap_ready = Ready;
        snap_f0 = {Adr0, Pointer0, Set_pointer0, Data_in0, Data_in0b, R_W0};
        snap_f1 = {Adr1, Pointer1, Set_pointer1, Data_in1, Data_in1b, R_W1};
    end

    always @(negedge Clk) begin
        cyc++;
        if (snap_rst) mdl_last = 1'b1;
        if (Start && !st_prev) begin
            cur = '{default: 0};
            cur.c_start = cyc; cur.gnt = int'(Gnt); cur.cmd = cmd_now; cur.ready_ok = snap_ready;
            if (snap_req0 && snap_req1) cur.exp_who = mdl_last ? 0 : 1;
            else if (snap_req1)         cur.exp_who = 1;
            else if (snap_req0)         cur.exp_who = 0;
            else                        cur.exp_who = 3;
            cur.exp_cmd = (cur.exp_who == 1) ? snap_f1 : snap_f0;
            mdl_last = (cur.exp_who == 1);
        end
        if (Start) cur.start_len++;
        if (Ack0 || Ack1) begin
            if (ack_prev) ack_long++;
            else begin
                cur.who = (Ack0 && Ack1) ? 2 : (Ack1 ? 1 : 0);
                cur.err = Err; cur.tout = Tout; cur.c_ack = cyc; cur.cmd_ack = cmd_now;
                obs_q.push_back(cur);
            end
        end
        st_prev = Start;
        ack_prev = Ack0 || Ack1;
    end

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int i = 0;
        while (obs_q.size() < n && i < budget) begin @(negedge Clk); i++; end
        ok = (obs_q.size() >= n);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Rst = 1'b1; Rst_t = 1'b1;
        repeat (3) @(negedge Clk);
        total++;
        if ({Ack0, Ack1, Err, Tout, Gnt, Busy, Start} !== 7'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000000", {Ack0, Ack1, Err, Tout, Gnt, Busy, Start});
        end
        total++;
        if (cmd_now !== 33'b0) begin bad++; $display("FAIL reset_cmd: got %h want 0", cmd_now); end
        total++;
        if ({Ack0_t, Ack1_t, Err_t, Tout_t, Gnt_t, Busy_t, Start_t, cmd_t} !== 40'b0) begin
            bad++; $display("FAIL reset_t: got %h want 0", {Ack0_t, Ack1_t, Err_t, Tout_t, Gnt_t, Busy_t, Start_t, cmd_t});
        end
        Rst = 1'b0; Rst_t = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        obs_q.delete();
        fld_rand = 1'b0; m_rand = 1'b0; m_drop = 2; m_busy = 20; m_err = 1'b0; gap_max = 0;
        Adr0 = 7'h4D; Pointer0 = 8'h02; Set_pointer0 = 1'b1; Data_in0 = 8'h99; Data_in0b = 8'h31; R_W0 = 1'b0;
        rem[0] = 1;
        wait_obs(1, 100, ok);
        repeat (6) @(negedge Clk);
        total++;
        if (!ok || obs_q.size() != 1) begin bad++; $display("FAIL single_count: got %0d acks want 1", obs_q.size()); end
        else begin
            total++;
            if (obs_q[0].cmd !== {7'h4D, 8'h02, 1'b1, 8'h99, 8'h31, 1'b0}) begin
                bad++; $display("FAIL single_cmd: got %h", obs_q[0].cmd);
            end
            total++;
            if (obs_q[0].start_len != 3) begin bad++; $display("FAIL single_start_len: got %0d want 3", obs_q[0].start_len); end
            total++;
            if (obs_q[0].c_ack - obs_q[0].c_start != 23) begin
                bad++; $display("FAIL single_latency: got %0d want 23", obs_q[0].c_ack - obs_q[0].c_start);
            end
            total++;
            if (obs_q[0].who != 0 || obs_q[0].err || obs_q[0].tout) begin
                bad++; $display("FAIL single_ack: who=%0d err=%0b tout=%0b want 0/0/0", obs_q[0].who, obs_q[0].err, obs_q[0].tout);
            end
        end
        total++;
        if (ack_long != 0) begin bad++; $display("FAIL ack_width: got %0d long pulses want 0", ack_long); end
    endtask

    task automatic test_contention();
        bit ok;
        int want[4] = '{0, 1, 0, 1};
        Rst = 1'b1; @(negedge Clk); Rst = 1'b0;
        obs_q.delete();
        fld_rand = 1'b1; m_drop = 1; m_busy = 2; m_err = 1'b0; gap_max = 0;
        rem[0] = 2; rem[1] = 2;
        wait_obs(4, 200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL contention_done: got %0d acks want 4", obs_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_q[i].who != want[i] || obs_q[i].gnt != want[i]) begin
                bad++; $display("FAIL contention_order[%0d]: ack=%0d gnt=%0d want %0d", i, obs_q[i].who, obs_q[i].gnt, want[i]);
            end
        end
    endtask

    task automatic test_error();
        bit ok;
        @(negedge Clk);
        obs_q.delete();
        m_drop = 1; m_busy = 3; m_err = 1'b1;
        rem[1] = 1;
        wait_obs(1, 100, ok);
        repeat (3) @(negedge Clk);
        m_err = 1'b0;
        total++;
        if (!ok || obs_q[0].who != 1 || !obs_q[0].err || obs_q[0].tout) begin
            bad++; $display("FAIL error_path: ok=%0b who=%0d err=%0b tout=%0b want 1/1/0", ok,
                            ok ? obs_q[0].who : -1, ok ? obs_q[0].err : 1'b0, ok ? obs_q[0].tout : 1'b0);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit blocked_ok = 1'b1;
        Ready_t = 1'b1;
        @(negedge Clk); Req0_t = 1'b1;
        @(negedge Clk);
        total++;
        if (Start_t !== 1'b1) begin bad++; $display("FAIL tout_grant: Start=%b want 1", Start_t); end
        n = 0;
        while (!(Ack0_t || Ack1_t) && n < 60) begin @(negedge Clk); n++; end
        total++;
        if (n != 16 || !Ack0_t || !Tout_t || Err_t || Start_t) begin
            bad++; $display("FAIL tout_issue: cycles=%0d ack0=%b tout=%b err=%b start=%b want 16/1/1/0/0", n, Ack0_t, Tout_t, Err_t, Start_t);
        end
        Req0_t = 1'b0; Ready_t = 1'b0; Req1_t = 1'b1;
        repeat (10) begin
            @(negedge Clk);
            if (Start_t || Busy_t) blocked_ok = 1'b0;
        end
        total++;
        if (!blocked_ok) begin bad++; $display("FAIL tout_block: grant seen while Ready=0 want none"); end
        Ready_t = 1'b1;
        @(negedge Clk);
        total++;
        if (Start_t !== 1'b1 || Gnt_t !== 1'b1) begin bad++; $display("FAIL tout_regrant: Start=%b Gnt=%b want 1/1", Start_t, Gnt_t); end
        Ready_t = 1'b0;
        n = 0;
        while (!(Ack0_t || Ack1_t) && n < 60) begin @(negedge Clk); n++; end
        total++;
        if (n != 17 || !Ack1_t || !Tout_t || Err_t || Start_t) begin
            bad++; $display("FAIL tout_busy: cycles=%0d ack1=%b tout=%b err=%b start=%b want 17/1/1/0/0", n, Ack1_t, Tout_t, Err_t, Start_t);
        end
        Req1_t = 1'b0;
        repeat (3) @(negedge Clk);
        Ready_t = 1'b1;
    endtask

    task automatic test_reset_busy();
        bit ok;
        int n = 0;
        @(negedge Clk);
        fld_rand = 1'b1; m_drop = 0; m_busy = 30; m_err = 1'b0;
        rem[0] = 1;
        while (!(Busy && !Start) && n < 50) begin @(negedge Clk); n++; end
        repeat (3) @(negedge Clk);
        obs_q.delete();
        Rst = 1'b1; rem[1] = 1;
        @(negedge Clk);
        Rst = 1'b0;
        total++;
        if ({Ack0, Ack1, Err, Tout, Gnt, Busy, Start} !== 7'b0 || cmd_now !== 33'b0) begin
            bad++; $display("FAIL rst_busy_outputs: got %b/%h want all 0", {Ack0, Ack1, Err, Tout, Gnt, Busy, Start}, cmd_now);
        end
        @(negedge Clk);
        total++;
        if (Start !== 1'b1 || Gnt !== 1'b0) begin bad++; $display("FAIL rst_busy_regrant: Start=%b Gnt=%b want 1/0", Start, Gnt); end
        wait_obs(2, 200, ok);
        repeat (5) @(negedge Clk);
        total++;
        if (!ok || obs_q.size() != 2 || obs_q[0].who != 0 || obs_q[1].who != 1) begin
            bad++; $display("FAIL rst_busy_acks: count=%0d want 2 in order 0,1", obs_q.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        int n0 = 0;
        @(negedge Clk);
        obs_q.delete(); err_q.delete();
        fld_rand = 1'b1; m_rand = 1'b1; gap_max = 3;
        rem[0] = 12; rem[1] = 12;
        wait_obs(24, 3000, ok);
        repeat (10) @(negedge Clk);
        m_rand = 1'b0;
        total++;
        if (!ok || obs_q.size() != 24 || err_q.size() != 24) begin
            bad++; $display("FAIL random_count: acks=%0d starts=%0d want 24", obs_q.size(), err_q.size());
        end else for (int i = 0; i < 24; i++) begin
            if (obs_q[i].who == 0) n0++;
            total++;
            if (obs_q[i].who != obs_q[i].exp_who) begin
                bad++; $display("FAIL random_who[%0d]: got %0d want %0d", i, obs_q[i].who, obs_q[i].exp_who);
            end
            total++;
            if (obs_q[i].cmd !== obs_q[i].exp_cmd || obs_q[i].cmd_ack !== obs_q[i].exp_cmd) begin
                bad++; $display("FAIL random_cmd[%0d]: got %h/%h want %h", i, obs_q[i].cmd, obs_q[i].cmd_ack, obs_q[i].exp_cmd);
            end
            total++;
            if (obs_q[i].err != err_q[i] || obs_q[i].tout || !obs_q[i].ready_ok) begin
                bad++; $display("FAIL random_status[%0d]: err=%0b tout=%0b ready=%0b want %0b/0/1", i, obs_q[i].err, obs_q[i].tout, obs_q[i].ready_ok, err_q[i]);
            end
        end
        total++;
        if (n0 != 12) begin bad++; $display("FAIL random_share: requester0 acks=%0d want 12", n0); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        @(negedge Clk);
        obs_q.delete();
        m_rand = 1'b0; m_drop = 0; m_busy = 1; m_err = 1'b0; gap_max = 0;
        rem[0] = 3; rem[1] = 3;
        wait_obs(6, 200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_done: got %0d acks want 6", obs_q.size()); end
        else for (int i = 1; i < 6; i++) begin
            total++;
            if (obs_q[i].c_ack - obs_q[i-1].c_ack != 4 || obs_q[i].who == obs_q[i-1].who) begin
                bad++; $display("FAIL b2b_gap[%0d]: gap=%0d who=%0d prev=%0d want 4 alternating", i,
                                obs_q[i].c_ack - obs_q[i-1].c_ack, obs_q[i].who, obs_q[i-1].who);
            end
        end
        total++;
        if (ack_long != 0) begin bad++; $display("FAIL ack_width_final: got %0d long pulses want 0", ack_long); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_error();
        test_timeout();
        test_reset_busy();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
